// File: rtl/note_pkg.sv
// note_pkg: shared note table, widths, repeat FSM states and step helpers.
package note_pkg;
  localparam int NUM_NOTES = 12;
  localparam int IDX_W = 4;
  localparam int FREQ_W = 12;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [FREQ_W-1:0] freq_t;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_NOTES - 1);
  // Must stay identical to the 7-segment note display decode.
  localparam freq_t NOTE_FREQ [NUM_NOTES] = '{
    12'd261, 12'd277, 12'd293, 12'd311, 12'd330, 12'd349,
    12'd370, 12'd392, 12'd415, 12'd440, 12'd466, 12'd494
  };
  function automatic freq_t note_freq(input idx_t i);
    return (i > LAST_IDX) ? '0 : NOTE_FREQ[i];
  endfunction
  function automatic idx_t step_idx(input idx_t i, input logic up, input logic dn);
    return (i > LAST_IDX) ? '0 :
           up ? ((i == LAST_IDX) ? '0 : i + 1'b1) :
           dn ? ((i == '0) ? LAST_IDX : i - 1'b1) : i;
  endfunction
endpackage

// File: rtl/note_selector_if.sv
// note_selector_if: raw buttons in, selected note / frequency out.
interface note_selector_if;
  import note_pkg::*;
  logic btnUp;
  logic btnDown;
  logic btnPlay;
  freq_t freq;
  idx_t noteIdx;
  logic playing;
  logic noteStep;
  modport master(output btnUp, btnDown, btnPlay, input freq, noteIdx, playing, noteStep);
  modport slave(input btnUp, btnDown, btnPlay, output freq, noteIdx, playing, noteStep);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter, debounced level and rise pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic sync1, sync2, db_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db <= 1'b0;
            db_q <= 1'b0;
            cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q <= db;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign rise = db & ~db_q;
endmodule

// File: rtl/note_selector.sv
// note_selector: debounced up/down/play buttons select a chromatic note
// with hold-to-repeat; registered note index, frequency and step pulse.
module note_selector
    import note_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 15_000_000
) (
    input logic clk,
    input logic rst_n,
    note_selector_if.slave bus
);
    localparam int TMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    typedef logic [TW-1:0] tmr_t;
    logic up_db, up_rise, dn_db, dn_rise, play_db, play_rise;
    logic up_only, dn_only, start_up, start_dn, held, expire, fire, do_up, do_dn;
    rpt_state_t state, state_n;
    logic dir_up, dir_up_n;
    tmr_t timer, timer_n;
    idx_t idx, idx_n;
    freq_t freq_r, freq_n;
    logic playing_r, play_n, step_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst_n(rst_n), .raw(bus.btnUp), .db(up_db), .rise(up_rise));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
        .clk(clk), .rst_n(rst_n), .raw(bus.btnDown), .db(dn_db), .rise(dn_rise));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
        .clk(clk), .rst_n(rst_n), .raw(bus.btnPlay), .db(play_db), .rise(play_rise));

    assign up_only = up_db & ~dn_db;
    assign dn_only = dn_db & ~up_db;
    assign start_up = up_rise & up_only;
    assign start_dn = dn_rise & dn_only;
    assign held = dir_up ? up_only : dn_only;
    assign expire = timer <= tmr_t'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dir_up <= 1'b0;
            timer <= '0;
            idx <= '0;
            freq_r <= '0;
            playing_r <= 1'b0;
            step_r <= 1'b0;
        end else begin
            state <= state_n;
            dir_up <= dir_up_n;
            timer <= timer_n;
            idx <= idx_n;
            freq_r <= freq_n;
            playing_r <= play_n;
            step_r <= idx_n != idx;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        dir_up_n = dir_up;
        case (state)
            IDLE: begin
                state_n = (start_up | start_dn) ? DELAY : IDLE;
                timer_n = (start_up | start_dn) ? tmr_t'(REPEAT_DELAY_CYCLES) : '0;
                dir_up_n = start_up ? 1'b1 : start_dn ? 1'b0 : dir_up;
            end
            DELAY, REPEAT: begin
                state_n = !held ? IDLE : expire ? REPEAT : state;
                timer_n = !held ? '0 : expire ? tmr_t'(REPEAT_PERIOD_CYCLES) : timer - 1'b1;
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    // freq is derived from next-state idx/playing so all outputs move on one edge.
    always_comb begin
        fire = (state == IDLE) ? (start_up | start_dn) : (state != IDLE) && held && expire;
        do_up = fire & ((state == IDLE) ? start_up : dir_up);
        do_dn = fire & ~do_up;
        idx_n = step_idx(idx, do_up, do_dn);
        play_n = playing_r ^ (play_rise & play_db);
        freq_n = play_n ? note_freq(idx_n) : '0;
    end

    assign bus.noteIdx = idx;
    assign bus.freq = freq_r;
    assign bus.playing = playing_r;
    assign bus.noteStep = step_r;
endmodule

// File: doc/note_selector.md
Name: note_selector

Overview:
Upstream stage of the note display and tone path. Turns three raw push-buttons into the currently selected musical note. Up/down step through the 12-note chromatic octave C4..B4, with wrap-around and hold-to-repeat; play toggles output on and off. Drives a 12-bit integer-Hz `freq` bus, which the 7-segment note display and the tone generator consume; `freq` is 0 when muted.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz).
- REPEAT_DELAY_CYCLES, 50_000_000: hold time before auto-repeat starts (500 ms).
- REPEAT_PERIOD_CYCLES, 15_000_000: interval between auto-repeat steps (150 ms).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btnUp  in  1  raw, asynchronous, bouncing; step up.
- btnDown  in  1  raw, asynchronous, bouncing; step down.
- btnPlay  in  1  raw, asynchronous, bouncing; toggle play.
- freq  out  12  note frequency in Hz from the note table when playing, else 0.
- noteIdx  out  4  selected note, 0=C .. 11=B; always valid, including while muted.
- playing  out  1  1 = note output enabled.
- noteStep  out  1  one-cycle pulse on every index change.

Behaviour:
- Reset (async assert, sync-released internally by the flops' first clk edge):
  - noteIdx=0, playing=0, freq=0, noteStep=0.
  - Debounced levels=0, repeat FSM=IDLE, all counters=0.
- Input conditioning, per button:
  - 2-FF synchronizer, then a debounce counter.
  - The counter resets whenever the synced level equals the debounced level.
  - Otherwise it increments; at DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - A registered copy of the debounced level gives a rise pulse (debounced 0->1).
- Play: each debounced btnPlay rise toggles playing. Release has no effect.
- Repeat FSM, shared by up/down:
  - IDLE: exactly one of upDb/downDb high on a rise of that button -> apply one step, load the timer with REPEAT_DELAY_CYCLES, go to DELAY.
  - DELAY: direction button still held alone -> count down; at timer expiry apply a step, load REPEAT_PERIOD_CYCLES, go to REPEAT.
  - REPEAT: while held alone, step at every expiry and reload REPEAT_PERIOD_CYCLES.
  - From DELAY or REPEAT: release of the active button, or the other button becoming high -> IDLE with no step.
  - upDb and downDb both high: no step ever; FSM held in IDLE.
- Step arithmetic, modulo 12:
  - Up: 11->0, else +1.
  - Down: 0->11, else -1.
  - Indices 12..15 are unreachable; if ever present, the next edge forces 0.
- Outputs:
  - noteIdx, freq and noteStep are all registered and update on the same edge.
  - freq = playing ? NOTE_FREQ[next idx] : 0, computed from the next-state values.
  - A play toggle and a step in the same cycle both take effect on that edge.
- Latency: raw level change held stable -> outputs change exactly DEBOUNCE_CYCLES+3 edges later:
  - 2 edges for the synchronizer;
  - DEBOUNCE_CYCLES edges for the debounce counter;
  - 1 edge to register the outputs.
- Bounce shorter than DEBOUNCE_CYCLES produces no event.
- Reset mid-hold or mid-debounce aborts everything. A button still held after reset release needs a fresh debounce, and then produces a rise and a step.
- Timers are sized with $clog2 of the largest parameter; no other width truncation.

Decomposition:
- Package note_pkg:
  - NUM_NOTES=12, IDX_W=4, FREQ_W=12.
  - NOTE_FREQ table: 261,277,293,311,330,349,370,392,415,440,466,494. It must match the display decode exactly.
  - Repeat FSM state enum IDLE/DELAY/REPEAT.
- Sub-module btn_debounce: synchronizer, debounce counter, debounced level and rise pulse; parameter DEBOUNCE_CYCLES. Instantiated three times.

Test Plan:
All directed runs use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=5.
1. Reset, then press btnPlay clean for 10 cycles -> playing=1 and freq=261 exactly 7 edges after the press; noteIdx=0.
2. Playing, idx 0: three clean btnUp taps -> noteIdx 1,2,3 and freq 277,293,311; one noteStep pulse per tap. At idx 11 (494) one tap -> idx 0, freq 261.
3. idx 0, tap btnDown -> idx 11, freq 494. Bouncy press (toggles of 1-3 cycles, then stable) -> exactly one step.
4. Hold btnUp for 60 cycles from idx 0 -> first step, second step 20 cycles later, then one every 5 cycles: idx 1..9 total. Release -> no further steps.
5. btnUp and btnDown pressed together, held 60 cycles -> no change to noteIdx or freq. Pressing btnDown during an up-repeat -> stepping stops at once.
6. Muted (playing=0) with idx 9 -> freq=0, noteIdx=9. Assert rst_n=0 mid-hold -> all outputs reset immediately (async); after release, the held button re-debounces and steps once.
